// File: rtl/balanced_word_gen.sv
// balanced_word_gen
// Stream generator for WIDTH-bit words that each carry at least MIN_ONES ones
// and MIN_ZEROES zeroes. A Galois LFSR supplies candidates. A candidate that
// fails the test is rejected. After MAX_TRIES consecutive rejects, the last
// candidate is patched into a qualifying word, so each word takes a bounded
// number of cycles. Words leave on a valid/ready handshake and stay stable
// until they are accepted.
`timescale 1ns/1ps

module balanced_word_gen #(
  parameter int              WIDTH      = 32,
  parameter int              MIN_ONES   = 5,
  parameter int              MIN_ZEROES = 5,
  parameter int              MAX_TRIES  = 8,
  parameter logic [WIDTH-1:0] SEED      = 32'hACE1_2BAD
) (
  input  logic             clk,
  input  logic             reset,        // asynchronous, active low
  input  logic             enable,
  input  logic             ready,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic             busy,
  output logic [7:0]       reject_count,
  output logic [15:0]      word_count
);

  // Counter wide enough to hold WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  // Galois right-shift mask for x^32 + x^22 + x^2 + x + 1
  // (bit positions 31, 21, 1 and 0).
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(32'h8020_0003);

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GEN   = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Reject parameter sets that cannot work, at elaboration time.
  if (WIDTH != 32) begin : g_bad_width
    $error("balanced_word_gen: the LFSR polynomial is defined for WIDTH=32 only");
  end
  if (MIN_ONES + MIN_ZEROES > WIDTH) begin : g_bad_mins
    $error("balanced_word_gen: MIN_ONES + MIN_ZEROES exceeds WIDTH");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("balanced_word_gen: SEED must be nonzero");
  end
  if (MAX_TRIES < 1 || MAX_TRIES > 255) begin : g_bad_tries
    $error("balanced_word_gen: MAX_TRIES must lie in 1..255");
  end

  // State registers and their next-state values
  logic [1:0]       state_reg,        state_next;
  logic [WIDTH-1:0] lfsr_reg,         lfsr_next;
  logic [WIDTH-1:0] candidate_reg,    candidate_next;
  logic [7:0]       tries_reg,        tries_next;
  logic [WIDTH-1:0] value_reg,        value_next;
  logic             valid_reg,        valid_next;
  logic [7:0]       reject_count_reg, reject_count_next;
  logic [15:0]      word_count_reg,   word_count_next;

  // Helper values derived from the current state
  logic [WIDTH-1:0] lfsr_step;
  logic [WIDTH-1:0] fallback_word;
  logic [CW-1:0]    ones_cnt;
  logic [CW-1:0]    zeroes_cnt;
  logic             qualifies;
  logic [8:0]       tries_inc;
  logic             more_tries;
  logic [7:0]       reject_inc;

  // One Galois LFSR step. The result is consumed only in GEN.
  assign lfsr_step = {1'b0, lfsr_reg[WIDTH-1:1]} ^ (lfsr_reg[0] ? TAPS : '0);

  // Count the one bits in the candidate under test.
  always_comb begin
    ones_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones_cnt = ones_cnt + CW'(candidate_reg[i]);
    end
  end

  assign zeroes_cnt = CW'(WIDTH) - ones_cnt;
  assign qualifies  = (ones_cnt >= CW'(MIN_ONES)) && (zeroes_cnt >= CW'(MIN_ZEROES));

  // Patch the candidate as follows:
  //   - force the low MIN_ONES bits to one;
  //   - force the next MIN_ZEROES bits to zero;
  //   - leave all other bits unchanged.
  // The result always qualifies.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fix
    if (gi < MIN_ONES) begin : g_one
      assign fallback_word[gi] = 1'b1;
    end else if (gi < MIN_ONES + MIN_ZEROES) begin : g_zero
      assign fallback_word[gi] = 1'b0;
    end else begin : g_keep
      assign fallback_word[gi] = candidate_reg[gi];
    end
  end

  // Arithmetic for the try counter and the reject counter.
  // The reject counter saturates at 255.
  assign tries_inc  = {1'b0, tries_reg} + 9'd1;
  assign more_tries = tries_inc < 9'(MAX_TRIES);
  assign reject_inc = (reject_count_reg == 8'hFF) ? 8'hFF : reject_count_reg + 8'd1;

  // Next-state logic for the IDLE -> GEN -> CHECK -> HOLD sequence.
  always_comb begin
    state_next        = state_reg;
    lfsr_next         = lfsr_reg;
    candidate_next    = candidate_reg;
    tries_next        = tries_reg;
    value_next        = value_reg;
    valid_next        = valid_reg;
    reject_count_next = reject_count_reg;
    word_count_next   = word_count_reg;

    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_GEN;
          tries_next = '0;
        end
      end

      ST_GEN: begin
        // If generation is aborted here, the LFSR keeps its value so that a
        // later restart continues the same sequence.
        if (enable) begin
          lfsr_next      = lfsr_step;
          candidate_next = lfsr_step;
          state_next     = ST_CHECK;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_CHECK: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (qualifies) begin
          value_next = candidate_reg;
          valid_next = 1'b1;
          state_next = ST_HOLD;
        end else begin
          reject_count_next = reject_inc;
          if (more_tries) begin
            tries_next = tries_inc[7:0];
            state_next = ST_GEN;
          end else begin
            value_next = fallback_word;
            valid_next = 1'b1;
            state_next = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        // Once offered, a word is never withdrawn. enable is ignored here.
        if (ready) begin
          word_count_next = word_count_reg + 16'd1;
          valid_next      = 1'b0;
          if (enable) begin
            state_next = ST_GEN;
            tries_next = '0;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Update the state registers. Reset clears everything and reloads the seed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= ST_IDLE;
      lfsr_reg         <= SEED;
      candidate_reg    <= '0;
      tries_reg        <= '0;
      value_reg        <= '0;
      valid_reg        <= 1'b0;
      reject_count_reg <= '0;
      word_count_reg   <= '0;
    end else begin
      state_reg        <= state_next;
      lfsr_reg         <= lfsr_next;
      candidate_reg    <= candidate_next;
      tries_reg        <= tries_next;
      value_reg        <= value_next;
      valid_reg        <= valid_next;
      reject_count_reg <= reject_count_next;
      word_count_reg   <= word_count_next;
    end
  end

  // Drive the outputs straight from the registers.
  assign value        = value_reg;
  assign valid        = valid_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign reject_count = reject_count_reg;
  assign word_count   = word_count_reg;

endmodule

// File: tb/tb_balanced_word_gen.sv
// Testbench for balanced_word_gen.
// The bench combines three kinds of check:
//   - a per-cycle vector table of hand-computed values;
//   - hand-written sequences for backpressure and for asynchronous reset;
//   - reference-model comparisons for a long stream and for the fallback path.
`timescale 1ns/1ps

module tb_balanced_word_gen;

  localparam logic [31:0] SEED = 32'hACE1_2BAD;

  logic        clk;
  logic        reset, enable, ready;
  logic [31:0] value;
  logic        valid, busy;
  logic [7:0]  reject_count;
  logic [15:0] word_count;

  logic        reset_fb, enable_fb, ready_fb;
  logic [31:0] value_fb;
  logic        valid_fb, busy_fb;
  logic [7:0]  reject_count_fb;
  logic [15:0] word_count_fb;

  int errors = 0;
  int checks = 0;

  balanced_word_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .ready(ready),
    .value(value), .valid(valid), .busy(busy),
    .reject_count(reject_count), .word_count(word_count)
  );

  balanced_word_gen #(
    .MIN_ONES(16), .MIN_ZEROES(16), .MAX_TRIES(1)
  ) dut_fb (
    .clk(clk), .reset(reset_fb), .enable(enable_fb), .ready(ready_fb),
    .value(value_fb), .valid(valid_fb), .busy(busy_fb),
    .reject_count(reject_count_fb), .word_count(word_count_fb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        rdy;
    logic        exp_valid;
    logic        exp_busy;
    logic [15:0] exp_wc;
    logic [31:0] exp_value;
  } vec_t;

  vec_t vecs [22];

  logic [31:0] m_lfsr;
  int          m_rej;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[31] = 1'b1;
      n[21] = n[21] ^ 1'b1;
      n[1]  = n[1] ^ 1'b1;
      n[0]  = n[0] ^ 1'b1;
    end
    return n;
  endfunction

  function automatic int pop(input logic [31:0] w);
    int c = 0;
    for (int b = 0; b < 32; b++) c += int'(w[b]);
    return c;
  endfunction

  // Reference filter: produce the next emitted word from m_lfsr.
  task automatic model_next(input int min1, input int min0, input int maxt,
                            output logic [31:0] w, output int nrej, output bit fb);
    logic [31:0] cand;
    int          p;
    bit          done;
    nrej = 0;
    fb   = 1'b0;
    w    = '0;
    done = 1'b0;
    for (int t = 0; t < maxt && !done; t++) begin
      m_lfsr = lfsr_adv(m_lfsr);
      cand   = m_lfsr;
      p      = pop(cand);
      if (p >= min1 && (32 - p) >= min0) begin
        w    = cand;
        done = 1'b1;
      end else begin
        nrej++;
        if (t == maxt - 1) begin
          w = cand;
          for (int b = 0; b < min1; b++) w[b] = 1'b1;
          for (int b = min1; b < min1 + min0; b++) w[b] = 1'b0;
          fb = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!valid && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(valid), 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    int          nrej, hs, last_cyc, first_cyc, extra, exp_rej;
    bit          fb;

    reset = 1'b0; enable = 1'b0; ready = 1'b0;
    reset_fb = 1'b0; enable_fb = 1'b0; ready_fb = 1'b0;

    // Columns: rst_n en rdy | expected valid, busy, word_count, value
    // (expected values are those seen just after the edge).
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 32'h0000_0000};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 32'h0000_0000};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0, 32'h0000_0000}; // GEN
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0, 32'h0000_0000}; // CHECK
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 32'hD650_95D5}; // HOLD, step 1
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 32'hD650_95D5}; // handshake
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1, 32'hD650_95D5};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 32'hEB08_4AE9}; // step 2
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 32'hEB08_4AE9}; // backpressure
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 32'hEB08_4AE9}; // enable ignored
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 32'hEB08_4AE9}; // -> IDLE
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 32'hEB08_4AE9};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 32'hEB08_4AE9}; // GEN
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 32'hEB08_4AE9}; // abort in GEN
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 32'hEB08_4AE9}; // GEN
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 32'hEB08_4AE9}; // CHECK (step 3)
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 32'hEB08_4AE9}; // abort in CHECK
    vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2, 32'hEB08_4AE9}; // GEN
    vecs[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2, 32'hEB08_4AE9}; // CHECK
    vecs[20] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd2, 32'hFAF2_12B8}; // step 4
    vecs[21] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd3, 32'hFAF2_12B8};

    for (int i = 0; i < 22; i++) begin
      reset  = vecs[i].rst_n;
      enable = vecs[i].en;
      ready  = vecs[i].rdy;
      tick();
      $display("vec %0d: valid=%0b busy=%0b wc=%0d value=%h rej=%0d",
               i, valid, busy, word_count, value, reject_count);
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_wc", i), 32'(word_count), 32'(vecs[i].exp_wc));
      check($sformatf("vec%0d_value", i), value, vecs[i].exp_value);
      check($sformatf("vec%0d_rej", i), 32'(reject_count), 32'd0);
    end

    // Backpressure: hold the word for 20 cycles, then drop enable,
    // then accept the word.
    reset = 1'b0;
    tick();
    reset = 1'b1; enable = 1'b1; ready = 1'b0;
    wait_valid("bp_first_valid", 10);
    check("bp_first_value", value, 32'hD650_95D5);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_hold_valid", 32'(valid), 32'd1);
      check("bp_hold_value", value, 32'hD650_95D5);
      check("bp_hold_wc", 32'(word_count), 32'd0);
    end
    enable = 1'b0;
    tick();
    check("bp_noretract_valid", 32'(valid), 32'd1);
    ready = 1'b1;
    tick();
    $display("bp accept: wc=%0d valid=%0b busy=%0b", word_count, valid, busy);
    check("bp_accept_wc", 32'(word_count), 32'd1);
    check("bp_accept_valid", 32'(valid), 32'd0);
    check("bp_accept_busy", 32'(busy), 32'd0);
    ready = 1'b0; enable = 1'b1;
    wait_valid("bp_resume_valid", 10);
    check("bp_resume_value", value, 32'hEB08_4AE9);

    // Asynchronous reset between edges while in HOLD.
    #3;
    reset = 1'b0;
    #1;
    $display("async reset: valid=%0b busy=%0b value=%h wc=%0d rej=%0d",
             valid, busy, value, word_count, reject_count);
    check("areset_valid", 32'(valid), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_value", value, 32'h0);
    check("areset_wc", 32'(word_count), 32'd0);
    check("areset_rej", 32'(reject_count), 32'd0);

    // Long stream with ready tied high, compared against the reference model.
    @(posedge clk);
    #1;
    reset = 1'b1; enable = 1'b1; ready = 1'b1;
    m_lfsr = SEED; m_rej = 0; hs = 0; last_cyc = -1; first_cyc = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (valid) begin
        model_next(5, 5, 8, w, nrej, fb);
        m_rej += nrej;
        exp_rej = (m_rej > 255) ? 255 : m_rej;
        if (hs < 3 || nrej != 0)
          $display("stream word %0d: value=%h expected %h rej=%0d", hs, value, w, reject_count);
        check("stream_value", value, w);
        check("stream_rej", 32'(reject_count), 32'(exp_rej));
        check("stream_pop_range", 32'(pop(value) >= 5 && pop(value) <= 27), 32'd1);
        if (last_cyc >= 0)
          check("stream_gap", 32'(cyc - last_cyc), 32'(3 + 2 * (nrej - int'(fb))));
        else
          first_cyc = cyc;
        last_cyc = cyc;
        hs++;
      end
    end
    check("stream_first_latency", 32'(first_cyc), 32'd2);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (valid) hs++;
    end
    $display("stream end: wc=%0d handshakes=%0d", word_count, hs);
    check("stream_wc", 32'(word_count), 32'(hs));
    check("stream_idle_busy", 32'(busy), 32'd0);

    // Fallback instance: MIN 16/16 and MAX_TRIES 1, run until rejects saturate.
    @(posedge clk);
    #1;
    reset_fb = 1'b1; enable_fb = 1'b1; ready_fb = 1'b1;
    m_lfsr = SEED; m_rej = 0; extra = 0;
    for (int cyc = 0; cyc < 6000 && extra < 30; cyc++) begin
      tick();
      if (valid_fb) begin
        model_next(16, 16, 1, w, nrej, fb);
        m_rej += nrej;
        exp_rej = (m_rej > 255) ? 255 : m_rej;
        check("fb_value", value_fb, w);
        check("fb_rej", 32'(reject_count_fb), 32'(exp_rej));
        check("fb_pop", 32'(pop(value_fb)), 32'd16);
        if (fb) check("fb_word_const", value_fb, 32'h0000_FFFF);
        if (m_rej >= 255) extra++;
      end
    end
    $display("fallback end: rej=%0d model_rejects=%0d words_after_sat=%0d",
             reject_count_fb, m_rej, extra);
    check("fb_budget", 32'(extra), 32'd30);
    check("fb_saturated", 32'(reject_count_fb), 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
